// File: rtl/moving_average_pkg.sv
// Shared types and width helpers for the moving_average boxcar filter.
package moving_average_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int WINDOW_DEFAULT = 4;

  typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

  // The window sum needs log2(WINDOW) growth bits on top of the sample width.
  function automatic int sum_width(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

  localparam int SUM_W_DEFAULT = sum_width(DATA_W_DEFAULT, WINDOW_DEFAULT);

  typedef logic signed [SUM_W_DEFAULT-1:0] sum_t;

endpackage

// File: rtl/moving_average_delay_line.sv
// DEPTH-deep sample shift register exposing its oldest entry; clear beats enable.
module moving_average_delay_line
  import moving_average_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = WINDOW_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_oldest
);

  // Index 0 holds the newest sample, DEPTH-1 the oldest.
  logic signed [DATA_W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else if (i_en) begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_oldest = r_stage[DEPTH-1];

endmodule

// File: rtl/moving_average.sv
// Streaming boxcar filter: registered floor mean of the last WINDOW signed samples.
// Optional sample-qualifier port eta_valid is enabled by defining MOVING_AVERAGE_VALID_EN.
module moving_average
  import moving_average_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic signed [DATA_W-1:0] eta_i1,
`ifdef MOVING_AVERAGE_VALID_EN
  input  logic                     eta_valid,
`endif
  output logic signed [DATA_W-1:0] topLet_o
);

  localparam int SUM_W = sum_width(DATA_W, WINDOW);
  localparam int SHIFT = $clog2(WINDOW);

  typedef logic signed [SUM_W-1:0] acc_t;

  generate
    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
      $error("moving_average: WINDOW must be a power of two and at least 2");
    end
  endgenerate

  logic                     w_en;
  logic signed [DATA_W-1:0] w_oldest;
  acc_t                     w_sum_next;
  acc_t                     r_sum;
  logic signed [DATA_W-1:0] r_avg;

`ifdef MOVING_AVERAGE_VALID_EN
  assign w_en = eta_valid;
`else
  assign w_en = 1'b1;
`endif

  moving_average_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (WINDOW)
  ) u_delay_line (
    .i_clk    (system1000),
    .i_clr    (system1000_rst),
    .i_en     (w_en),
    .i_data   (eta_i1),
    .o_oldest (w_oldest)
  );

  // Incremental update: add the arriving sample, retire the one leaving the window.
  assign w_sum_next = r_sum + acc_t'(eta_i1) - acc_t'(w_oldest);

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_sum <= '0;
      r_avg <= '0;
    end else if (w_en) begin
      r_sum <= w_sum_next;
      // Arithmetic shift floors toward -inf; the mean always fits back in DATA_W.
      r_avg <= DATA_W'(w_sum_next >>> SHIFT);
    end
  end

  assign topLet_o = r_avg;

endmodule

// File: tb/tb_moving_average.sv
// Self-checking bench for moving_average (WINDOW=4): directed plan plus randomized run vs. a queue model.
module tb_moving_average;

  localparam int W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] din;
  logic signed [7:0] dout;
  logic              valid;

  int tests = 0;
  int fails = 0;
  int hist[$];

  always #5 clk = ~clk;

  moving_average #(.DATA_W(8), .WINDOW(W)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .eta_i1         (din),
`ifdef MOVING_AVERAGE_VALID_EN
    .eta_valid      (valid),
`endif
    .topLet_o       (dout)
  );

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Mean of the window as plain integer arithmetic, floored toward -inf.
  function automatic int model_mean();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return floor_div(s, W);
  endfunction

  task automatic check(input string tag, input int exp);
    logic signed [7:0] e;
    e = exp[7:0];
    tests++;
    assert (dout === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, dout, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input int s, input bit r, input bit v);
    @(negedge clk);
    din   = s[7:0];
    rst   = r;
    valid = v;
    @(posedge clk);
    #1;
    if (r) begin
      hist = {};
      for (int i = 0; i < W; i++) hist.push_back(0);
    end else begin
`ifdef MOVING_AVERAGE_VALID_EN
      if (v) begin
        hist.push_back(s);
        void'(hist.pop_front());
      end
`else
      hist.push_back(s);
      void'(hist.pop_front());
`endif
    end
    check("model", model_mean());
  endtask

  int exp_pos8[6] = '{2, 4, 6, 8, 8, 8};
  int exp_neg8[5] = '{-2, -4, -6, -8, -8};
  int exp_max[4]  = '{31, 63, 95, 127};
  int exp_min[4]  = '{-32, -64, -96, -128};

  initial begin
    rst = 1'b1; din = '0; valid = 1'b1;
    for (int i = 0; i < W; i++) hist.push_back(0);

    step(55, 1, 1);
    step(-77, 1, 1);
    check("reset_zero", 0);

    for (int i = 0; i < 6; i++) begin step(8, 0, 1); check("const_8", exp_pos8[i]); end

    step(0, 1, 1);
    for (int i = 0; i < 5; i++) begin step(-8, 0, 1); check("const_m8", exp_neg8[i]); end

    step(0, 1, 1);
    for (int i = 0; i < 5; i++) begin step(-1, 0, 1); check("const_m1", -1); end

    step(0, 1, 1);
    for (int i = 0; i < 4; i++) begin step(127, 0, 1); check("max_127", exp_max[i]); end
    step(127, 0, 1); check("max_hold", 127);

    step(0, 1, 1);
    for (int i = 0; i < 4; i++) begin step(-128, 0, 1); check("min_m128", exp_min[i]); end
    step(-128, 0, 1); check("min_hold", -128);

    step(0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 127 : -128, 0, 1);
      if (i >= 3) check("alt_extreme", -1);
    end

    for (int i = 0; i < 5; i++) step(8, 0, 1);
    check("steady_8", 8);
    step(8, 1, 1); check("mid_reset", 0);
    for (int i = 0; i < 4; i++) begin step(8, 0, 1); check("after_reset", exp_pos8[i]); end

`ifdef MOVING_AVERAGE_VALID_EN
    step(0, 1, 1);
    step(8, 0, 1); check("valid_1", 2);
    step(8, 0, 0); check("valid_0a", 2);
    step(8, 0, 0); check("valid_0b", 2);
    step(8, 0, 1); check("valid_1b", 4);
    step(8, 1, 0); check("reset_over_valid", 0);
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 255) - 128, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
    end
`endif

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 255) - 128, ($urandom_range(0, 31) == 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
